// File: rtl/sar_adc_ctrl.sv
// Successive-approximation sequencer: drives the sample/hold switch and the
// DAC trial code, reads the comparator back one bit per decision, and hands
// each finished word to the SoC side over a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a registered START request; SAMPLE=0, DAC_CODE=0
// SAMP   | sample/hold switch closed for SAMPLE_CYCLES cycles
// SETTLE | trial code (working code with bit idx set) settling on the DAC
// DECIDE | comparator decision captured into bit idx at the end of the cycle
//
// START is registered once before IDLE acts on it. That single cycle of
// request latency is why the first result lands one cycle later than the
// continuous-mode conversion period.
module sar_adc_ctrl #(
  parameter int RES           = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic           START,
  input  logic           CONTINUOUS,
  input  logic           COMP_IN,
  output logic           SAMPLE,
  output logic [RES-1:0] DAC_CODE,
  output logic           BUSY,
  output logic [RES-1:0] RESULT,
  output logic           RESULT_VALID,
  input  logic           RESULT_READY,
  output logic           OVERRUN,
  input  logic           OVR_CLR
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES + SETTLE_CYCLES + 1);
  localparam int IDX_W = $clog2(RES);
  localparam logic [CNT_W-1:0] SAMP_LOAD   = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(RES - 1);
  localparam logic [RES-1:0]   MSB_ONLY    = {1'b1, {(RES-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMP   = 2'd1,
    SETTLE = 2'd2,
    DECIDE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [RES-1:0]   code, code_n;
  logic [RES-1:0]   dac_n;
  logic [RES-1:0]   res_n;
  logic             start_q, start_n;
  logic             done;

  // Next-state, next-output and working-code update for the sequencer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    code_n  = code;
    dac_n   = DAC_CODE;
    res_n   = '0;
    start_n = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        dac_n = '0;
        if (start_q) begin
          state_n = SAMP;
          cnt_n   = SAMP_LOAD;
        end else begin
          start_n = START;
        end
      end
      SAMP: begin
        dac_n = '0;
        if (cnt == '0) begin
          idx_n  = MSB_IDX;
          code_n = '0;
          dac_n  = MSB_ONLY;
          if (SETTLE_CYCLES > 0) begin
            state_n = SETTLE;
            cnt_n   = SETTLE_LOAD;
          end else begin
            state_n = DECIDE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_n = DECIDE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DECIDE: begin
        code_n[idx] = COMP_IN;
        if (idx != '0) begin
          idx_n = idx - IDX_W'(1);
          dac_n = code_n | (RES'(1) << idx_n);
          if (SETTLE_CYCLES > 0) begin
            state_n = SETTLE;
            cnt_n   = SETTLE_LOAD;
          end else begin
            state_n = DECIDE;
          end
        end else begin
          done  = 1'b1;
          res_n = code_n;
          dac_n = '0;
          if (CONTINUOUS) begin
            state_n = SAMP;
            cnt_n   = SAMP_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        dac_n   = '0;
      end
    endcase
  end

  // State register plus registered analog-side outputs.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      code     <= '0;
      start_q  <= 1'b0;
      SAMPLE   <= 1'b0;
      DAC_CODE <= '0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      code     <= code_n;
      start_q  <= start_n;
      SAMPLE   <= (state_n == SAMP);
      DAC_CODE <= dac_n;
      BUSY     <= (state_n != IDLE);
    end
  end

  // Result handshake: a new word always loads; overwriting an unaccepted word flags OVERRUN.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      if (done) begin
        RESULT       <= res_n;
        RESULT_VALID <= 1'b1;
      end else if (RESULT_VALID && RESULT_READY) begin
        RESULT_VALID <= 1'b0;
      end
      if (done && RESULT_VALID && !RESULT_READY) begin
        OVERRUN <= 1'b1;
      end else if (OVR_CLR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: a default instance and a zero-settle instance share
// stimulus; each sees an ideal comparator against its own DAC code.
module tb_sar_adc_ctrl;

  localparam int RES = 10;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic           HRESETn, START, CONTINUOUS, RESULT_READY, OVR_CLR;
  logic [RES-1:0] vin;
  int             comp_mode;  // 0: ideal comparator, 1: tied high, 2: tied low

  logic           comp_a, samp_a, busy_a, valid_a, ovr_a;
  logic [RES-1:0] dac_a, res_a;
  logic           comp_b, samp_b, busy_b, valid_b, ovr_b;
  logic [RES-1:0] dac_b, res_b;

  int errors = 0;
  int checks = 0;

  assign comp_a = (comp_mode == 1) ? 1'b1 : (comp_mode == 2) ? 1'b0 : (dac_a <= vin);
  assign comp_b = (comp_mode == 1) ? 1'b1 : (comp_mode == 2) ? 1'b0 : (dac_b <= vin);

  sar_adc_ctrl #(.RES(RES), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .START(START), .CONTINUOUS(CONTINUOUS),
    .COMP_IN(comp_a), .SAMPLE(samp_a), .DAC_CODE(dac_a), .BUSY(busy_a),
    .RESULT(res_a), .RESULT_VALID(valid_a), .RESULT_READY(RESULT_READY),
    .OVERRUN(ovr_a), .OVR_CLR(OVR_CLR));

  sar_adc_ctrl #(.RES(RES), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(0)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .START(START), .CONTINUOUS(CONTINUOUS),
    .COMP_IN(comp_b), .SAMPLE(samp_b), .DAC_CODE(dac_b), .BUSY(busy_b),
    .RESULT(res_b), .RESULT_VALID(valid_b), .RESULT_READY(RESULT_READY),
    .OVERRUN(ovr_b), .OVR_CLR(OVR_CLR));

  // Binary search: trial k keeps the input's bits above the tested one and sets the tested bit.
  function automatic logic [RES-1:0] trial_code(input logic [RES-1:0] v, input int k);
    logic [RES-1:0] keep;
    keep = '1;
    keep = keep << (RES - k);
    return (v & keep) | (RES'(1) << (RES - 1 - k));
  endfunction

  function automatic logic [RES-1:0] expected_word(input logic [RES-1:0] v, input int mode);
    if (mode == 1) return '1;
    if (mode == 2) return '0;
    return v;
  endfunction

  // Load time of the n-th word in continuous mode, counted in edges after START is seen.
  function automatic bit is_load(input int t, input int last);
    return (t >= 25) && (((t - 25) % 24) == 0) && (t <= last);
  endfunction

  task automatic do_reset;
    HRESETn = 1'b0; START = 1'b0; CONTINUOUS = 1'b0;
    RESULT_READY = 1'b0; OVR_CLR = 1'b0; comp_mode = 0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  // One START pulse; reports the edge at which RESULT_VALID was first seen on each DUT.
  task automatic run_conv(input logic [RES-1:0] v, input int mode, input bit accept,
                          output int lat_a, output int lat_b,
                          output logic [RES-1:0] r_a, output logic [RES-1:0] r_b);
    vin = v; comp_mode = mode;
    lat_a = -1; lat_b = -1; r_a = '0; r_b = '0;
    @(negedge HCLK);
    START = 1'b1;
    for (int e = 0; e < 60 && (lat_a < 0 || lat_b < 0); e++) begin
      @(negedge HCLK);
      START = 1'b0;
      if (lat_a < 0 && valid_a) begin lat_a = e; r_a = res_a; end
      if (lat_b < 0 && valid_b) begin lat_b = e; r_b = res_b; end
    end
    if (accept) begin
      RESULT_READY = 1'b1;
      @(negedge HCLK);
      RESULT_READY = 1'b0;
    end
  endtask

  task automatic test_reset;
    HRESETn = 1'b0; START = 1'b1; CONTINUOUS = 1'b0;
    RESULT_READY = 1'b0; OVR_CLR = 1'b0; comp_mode = 0; vin = '0;
    repeat (2) @(negedge HCLK);
    checks++;
    if ({samp_a, dac_a, busy_a, res_a, valid_a, ovr_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs %b expected all zero", {samp_a, dac_a, busy_a, res_a, valid_a, ovr_a});
    end
    checks++;
    if ({samp_b, dac_b, busy_b, res_b, valid_b, ovr_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: outputs %b expected all zero", {samp_b, dac_b, busy_b, res_b, valid_b, ovr_b});
    end
    START = 1'b0;
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_held: busy=%b expected 0", busy_a);
    end
  endtask

  task automatic test_basic;
    logic [RES-1:0] trials[$];
    logic [RES-1:0] prev_dac = '0;
    logic [RES-1:0] rres = '0, rres_b = '0;
    logic [63:0]    smask = '0;
    logic           prev_busy = 1'b0;
    int             v_rise = -1, b_rise = -1, b_fall = -1;
    logic [4*RES-1:0] first4;
    do_reset();
    vin = 10'h2A5; comp_mode = 0;
    @(negedge HCLK);
    START = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(negedge HCLK);
      START = 1'b0;
      if (samp_a) smask |= (64'd1 << e);
      if (dac_a != prev_dac && dac_a != '0) trials.push_back(dac_a);
      prev_dac = dac_a;
      if (prev_busy && !busy_a && b_fall < 0) b_fall = e;
      prev_busy = busy_a;
      if (valid_a && v_rise < 0) begin v_rise = e; rres = res_a; end
      if (valid_b && b_rise < 0) begin b_rise = e; rres_b = res_b; end
    end
    checks++;
    if (smask !== 64'h1E) begin
      errors++;
      $display("FAIL basic_sample_window: got %h expected %h", smask, 64'h1E);
    end
    checks++;
    if (trials.size() != RES) begin
      errors++;
      $display("FAIL basic_trial_count: got %0d expected %0d", trials.size(), RES);
    end
    for (int k = 0; k < RES && k < trials.size(); k++) begin
      checks++;
      if (trials[k] !== trial_code(vin, k)) begin
        errors++;
        $display("FAIL basic_trial_%0d: got %h expected %h", k, trials[k], trial_code(vin, k));
      end
    end
    if (trials.size() >= 4) begin
      first4 = {trials[0], trials[1], trials[2], trials[3]};
      checks++;
      if (first4 !== {10'h200, 10'h300, 10'h280, 10'h2C0}) begin
        errors++;
        $display("FAIL basic_first_trials: got %h expected %h", first4, {10'h200, 10'h300, 10'h280, 10'h2C0});
      end
    end
    checks++;
    if (v_rise != 25) begin errors++; $display("FAIL basic_latency: got %0d expected 25", v_rise); end
    checks++;
    if (b_fall != 25) begin errors++; $display("FAIL basic_busy_fall: got %0d expected 25", b_fall); end
    checks++;
    if (rres !== 10'h2A5) begin errors++; $display("FAIL basic_result: got %h expected 2a5", rres); end
    checks++;
    if (b_rise != 15) begin errors++; $display("FAIL settle0_latency: got %0d expected 15", b_rise); end
    checks++;
    if (rres_b !== 10'h2A5) begin errors++; $display("FAIL settle0_result: got %h expected 2a5", rres_b); end
    RESULT_READY = 1'b1;
    @(negedge HCLK);
    RESULT_READY = 1'b0;
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_accept: valid=%b expected 0", valid_a); end
  endtask

  task automatic test_ties;
    int la, lb;
    logic [RES-1:0] ra, rb;
    do_reset();
    for (int mode = 1; mode <= 2; mode++) begin
      run_conv(RES'($urandom_range(0, 1023)), mode, 1'b1, la, lb, ra, rb);
      checks++;
      if (ra !== expected_word('0, mode) || la != 25) begin
        errors++;
        $display("FAIL tie_mode%0d_a: got %h at %0d expected %h at 25", mode, ra, la, expected_word('0, mode));
      end
      checks++;
      if (rb !== expected_word('0, mode) || lb != 15) begin
        errors++;
        $display("FAIL tie_mode%0d_b: got %h at %0d expected %h at 15", mode, rb, lb, expected_word('0, mode));
      end
    end
  endtask

  task automatic test_random_single;
    int la, lb;
    logic [RES-1:0] ra, rb, v;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? RES'(0) : (i == 1) ? RES'(1023) : RES'($urandom_range(0, 1023));
      run_conv(v, 0, 1'b1, la, lb, ra, rb);
      checks++;
      if (ra !== v || la != 25) begin
        errors++;
        $display("FAIL single_%0d_a: got %h at %0d expected %h at 25", i, ra, la, v);
      end
      checks++;
      if (rb !== v || lb != 15) begin
        errors++;
        $display("FAIL single_%0d_b: got %h at %0d expected %h at 15", i, rb, lb, v);
      end
    end
  endtask

  task automatic test_overrun;
    int first = -1;
    do_reset();
    vin = 10'h100; CONTINUOUS = 1'b1;
    @(negedge HCLK);
    START = 1'b1;
    for (int e = 0; e < 60; e++) begin
      @(negedge HCLK);
      START = 1'b0;
      if (valid_a && first < 0) begin
        first = e;
        checks++;
        if (res_a !== 10'h100) begin errors++; $display("FAIL ovr_first_word: got %h expected 100", res_a); end
        vin = 10'h155;
        CONTINUOUS = 1'b0;
      end
    end
    checks++;
    if (first != 25) begin errors++; $display("FAIL ovr_first_latency: got %0d expected 25", first); end
    checks++;
    if ({res_a, valid_a, ovr_a, busy_a} !== {10'h155, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovr_set: result=%h valid=%b overrun=%b busy=%b expected 155 1 1 0", res_a, valid_a, ovr_a, busy_a);
    end
    OVR_CLR = 1'b1;
    @(negedge HCLK);
    OVR_CLR = 1'b0;
    @(negedge HCLK);
    checks++;
    if ({res_a, valid_a, ovr_a} !== {10'h155, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovr_clear: result=%h valid=%b overrun=%b expected 155 1 0", res_a, valid_a, ovr_a);
    end
  endtask

  task automatic test_continuous_ready;
    int rises[$];
    logic [RES-1:0] words[$];
    logic prev_v = 1'b0, ovr_seen = 1'b0;
    logic [RES-1:0] v;
    int idle_at = -1;
    do_reset();
    v = RES'($urandom_range(0, 1023));
    vin = v; CONTINUOUS = 1'b1; RESULT_READY = 1'b1;
    @(negedge HCLK);
    START = 1'b1;
    for (int e = 0; e < 100; e++) begin
      @(negedge HCLK);
      START = 1'b0;
      if (valid_a && !prev_v) begin rises.push_back(e); words.push_back(res_a); end
      prev_v = valid_a;
      if (ovr_a) ovr_seen = 1'b1;
    end
    CONTINUOUS = 1'b0;
    for (int e = 0; e < 40 && idle_at < 0; e++) begin
      @(negedge HCLK);
      if (!busy_a) idle_at = e;
    end
    RESULT_READY = 1'b0;
    checks++;
    if (rises.size() != 4) begin errors++; $display("FAIL cont_count: got %0d expected 4", rises.size()); end
    if (rises.size() > 0) begin
      checks++;
      if (rises[0] != 25) begin errors++; $display("FAIL cont_first: got %0d expected 25", rises[0]); end
    end
    for (int i = 1; i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != 24) begin
        errors++;
        $display("FAIL cont_period_%0d: got %0d expected 24", i, rises[i] - rises[i-1]);
      end
    end
    for (int i = 0; i < words.size(); i++) begin
      checks++;
      if (words[i] !== v) begin errors++; $display("FAIL cont_word_%0d: got %h expected %h", i, words[i], v); end
    end
    checks++;
    if (ovr_seen !== 1'b0) begin errors++; $display("FAIL cont_no_overrun: overrun=%b expected 0", ovr_seen); end
    checks++;
    if (idle_at < 0) begin errors++; $display("FAIL cont_stop: busy never fell, expected idle"); end
  endtask

  task automatic test_start_ignored;
    int count = 0, first = -1;
    logic prev_v = 1'b0;
    logic [RES-1:0] v, word = '0;
    do_reset();
    v = RES'($urandom_range(0, 1023));
    vin = v; RESULT_READY = 1'b1;
    @(negedge HCLK);
    START = 1'b1;
    for (int e = 0; e < 80; e++) begin
      @(negedge HCLK);
      START = (e >= 2 && e < 10);
      if (valid_a && !prev_v) begin
        count++;
        if (first < 0) begin first = e; word = res_a; end
      end
      prev_v = valid_a;
    end
    RESULT_READY = 1'b0;
    checks++;
    if (count != 1) begin errors++; $display("FAIL ignore_count: got %0d results expected 1", count); end
    checks++;
    if (first != 25 || word !== v) begin
      errors++;
      $display("FAIL ignore_result: got %h at %0d expected %h at 25", word, first, v);
    end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy=%b expected 0", busy_a); end
  endtask

  task automatic test_reset_mid;
    int la, lb;
    logic [RES-1:0] ra, rb, v;
    do_reset();
    run_conv(RES'($urandom_range(0, 1023)), 0, 1'b0, la, lb, ra, rb);
    vin = RES'($urandom_range(0, 1023));
    @(negedge HCLK);
    START = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(negedge HCLK);
      START = 1'b0;
      if (e == 11) begin
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL midreset_busy: busy=%b expected 1", busy_a); end
        HRESETn = 1'b0;
      end
    end
    @(negedge HCLK);
    checks++;
    if ({samp_a, dac_a, busy_a, res_a, valid_a, ovr_a} !== '0) begin
      errors++;
      $display("FAIL midreset_a: outputs %b expected all zero", {samp_a, dac_a, busy_a, res_a, valid_a, ovr_a});
    end
    checks++;
    if ({samp_b, dac_b, busy_b, res_b, valid_b, ovr_b} !== '0) begin
      errors++;
      $display("FAIL midreset_b: outputs %b expected all zero", {samp_b, dac_b, busy_b, res_b, valid_b, ovr_b});
    end
    HRESETn = 1'b1;
    v = RES'($urandom_range(0, 1023));
    run_conv(v, 0, 1'b1, la, lb, ra, rb);
    checks++;
    if (ra !== v || la != 25) begin
      errors++;
      $display("FAIL midreset_after: got %h at %0d expected %h at 25", ra, la, v);
    end
  endtask

  task automatic test_accept_same_cycle;
    logic [RES-1:0] v1, v2;
    do_reset();
    v1 = RES'($urandom_range(0, 511));
    v2 = RES'($urandom_range(512, 1023));
    vin = v1; CONTINUOUS = 1'b1;
    @(negedge HCLK);
    START = 1'b1;
    for (int e = 0; e < 52; e++) begin
      @(negedge HCLK);
      START = 1'b0;
      if (e == 25) begin
        checks++;
        if ({valid_a, res_a} !== {1'b1, v1}) begin
          errors++;
          $display("FAIL same_first: valid=%b result=%h expected 1 %h", valid_a, res_a, v1);
        end
        vin = v2;
        CONTINUOUS = 1'b0;
      end
      if (e == 48) RESULT_READY = 1'b1;
      if (e == 49) begin
        checks++;
        if ({valid_a, res_a, ovr_a} !== {1'b1, v2, 1'b0}) begin
          errors++;
          $display("FAIL same_cycle: valid=%b result=%h overrun=%b expected 1 %h 0", valid_a, res_a, ovr_a, v2);
        end
      end
      if (e == 50) begin
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("FAIL same_then_accept: valid=%b expected 0", valid_a); end
      end
    end
    RESULT_READY = 1'b0;
  endtask

  // Continuous conversions with random READY/OVR_CLR against a cycle-level handshake model.
  task automatic test_random;
    logic mv = 1'b0, mo = 1'b0, load, set;
    logic [RES-1:0] mr = '0;
    do_reset();
    CONTINUOUS = 1'b1;
    vin = RES'($urandom_range(0, 1023));
    for (int e = -1; e < 150; e++) begin
      if (e >= 0) begin
        checks++;
        if ({valid_a, res_a, ovr_a} !== {mv, mr, mo}) begin
          errors++;
          $display("FAIL random_edge%0d: valid=%b result=%h overrun=%b expected %b %h %b",
                   e, valid_a, res_a, ovr_a, mv, mr, mo);
        end
        if (is_load(e, 145)) vin = RES'($urandom_range(0, 1023));
      end
      if (e == 121) CONTINUOUS = 1'b0;
      START = (e == -1);
      RESULT_READY = 1'($urandom_range(0, 1));
      OVR_CLR = ($urandom_range(0, 3) == 0);
      load = is_load(e + 1, 145);
      set = load && mv && !RESULT_READY;
      if (load) begin
        mr = vin;
        mv = 1'b1;
      end else if (mv && RESULT_READY) begin
        mv = 1'b0;
      end
      if (set) mo = 1'b1;
      else if (OVR_CLR) mo = 1'b0;
      @(negedge HCLK);
    end
    START = 1'b0; RESULT_READY = 1'b0; OVR_CLR = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL random_idle: busy=%b expected 0", busy_a); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_random_single();
    test_overrun();
    test_continuous_ready();
    test_start_ignored();
    test_reset_mid();
    test_accept_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation sequencer for an off-chip or on-chip analog front end reached through an analog pad. It drives the sample/hold switch and the trial code of the capacitive/R-2R DAC, and reads the single-bit comparator decision back. It delivers each converted word to the SoC side over a valid/ready handshake. It sits between the analog pad/comparator macro and an APB/AHB peripheral wrapper.

Parameters:
RES, 10, conversion resolution in bits; legal range 2..16.
SAMPLE_CYCLES, 4, cycles SAMPLE is held high per conversion; must be at least 1.
SETTLE_CYCLES, 1, extra cycles the DAC trial code is held before each comparator decision; must be at least 0.

Ports:
HCLK  input  1  single clock, rising-edge.
HRESETn  input  1  synchronous, active-low reset.
START  input  1  conversion request; sampled only in IDLE.
CONTINUOUS  input  1  when 1, back-to-back conversions without returning to IDLE.
COMP_IN  input  1  comparator decision: 1 means analog input is at or above the DAC code. Already synchronised upstream.
SAMPLE  output  1  sample/hold switch enable.
DAC_CODE  output  RES  trial code to the DAC.
BUSY  output  1  high in any state other than IDLE.
RESULT  output  RES  last completed conversion.
RESULT_VALID  output  1  RESULT holds an unconsumed word.
RESULT_READY  input  1  consumer accepts RESULT when RESULT_VALID && RESULT_READY.
OVERRUN  output  1  sticky; set when a result is overwritten while unconsumed.
OVR_CLR  input  1  clears OVERRUN.

Behaviour:
- Reset (HRESETn=0 at a rising edge): state IDLE; SAMPLE=0, DAC_CODE=0, BUSY=0, RESULT=0, RESULT_VALID=0, OVERRUN=0. A reset mid-conversion aborts it and discards the partial result.
- All outputs are registered.
- States: IDLE, SAMP, SETTLE, DECIDE.
- IDLE: DAC_CODE=0, SAMPLE=0. If START=1, go to SAMP.
- SAMP: SAMPLE=1, DAC_CODE=0, for exactly SAMPLE_CYCLES cycles. Then the bit index i=RES-1, the working code is cleared, and the state goes to SETTLE, or to DECIDE if SETTLE_CYCLES=0.
- SETTLE: DAC_CODE = working code with bit i set, held for SETTLE_CYCLES cycles, then DECIDE.
- DECIDE: one cycle, DAC_CODE unchanged. COMP_IN is sampled at the end of this cycle. Bit i of the working code takes the value of COMP_IN.
  - If i>0: decrement i and go to SETTLE/DECIDE.
  - If i=0: load RESULT with the final code and set RESULT_VALID. Then go to SAMP if CONTINUOUS=1, else IDLE.
- Latency: with START seen high at edge 0, RESULT_VALID rises after edge SAMPLE_CYCLES + RES*(SETTLE_CYCLES+1) + 1. With defaults this is 25 cycles.
  - In continuous mode, the conversion period is SAMPLE_CYCLES + RES*(SETTLE_CYCLES+1) cycles.
- START while BUSY=1 is ignored; there is no queueing. CONTINUOUS is sampled only at the end of each conversion. Clearing it mid-conversion lets the current conversion finish, then the block returns to IDLE.
- Handshake: RESULT/RESULT_VALID remain stable until accepted. Acceptance clears RESULT_VALID on the next edge.
- New result in the same cycle as acceptance: the new word loads, RESULT_VALID stays 1, OVERRUN is not set.
- New result while RESULT_VALID=1 and not accepted that cycle: RESULT is overwritten with the new word and OVERRUN is set.
- OVR_CLR=1 clears OVERRUN. If a set event and OVR_CLR occur in the same cycle, the set wins.
- Width rules: DAC_CODE and RESULT are unsigned RES-bit values. An all-ones COMP_IN yields 2^RES-1; an all-zero COMP_IN yields 0. No arithmetic overflow is possible.

Test Plan:
- Defaults, comparator model with Vin code 0x2A5 (COMP_IN = DAC_CODE <= 0x2A5), one START pulse -> DAC_CODE trial sequence 0x200, 0x300, 0x280, 0x2C0, ... Then RESULT=0x2A5 with RESULT_VALID rising exactly 25 cycles after START, BUSY falling the same cycle, SAMPLE high for cycles 1-4.
- COMP_IN tied 1, then tied 0 -> RESULT=0x3FF, then 0x000. SETTLE_CYCLES=0 variant -> latency 15 cycles.
- CONTINUOUS=1, RESULT_READY=0 for two conversions (values 0x100 then 0x155) -> RESULT=0x155 and OVERRUN=1. OVR_CLR pulse -> OVERRUN=0. With RESULT_READY=1 throughout -> no OVERRUN, one result per 24 cycles.
- START re-asserted during conversion cycles 3-10 -> ignored, exactly one result produced, no restart.
- HRESETn low at cycle 12 of a conversion -> next cycle all outputs at reset values. A later START produces a correct full conversion.
- Accept in the same cycle a new result lands (continuous mode) -> RESULT_VALID stays 1, new value present, OVERRUN=0.
